// File: rtl/turbo_pkg.sv
// Shared turbo-codec definitions: block/tail widths, interleaver constants,
// the encoder sequencer state type and the 16-bit interleaver map.
package turbo_pkg;

    localparam int DW         = 16;
    localparam int TW         = 2;
    localparam int CW         = DW + TW;
    localparam int ILV_STRIDE = 5;
    localparam int ILV_OFFSET = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ1,
        ST_WAIT1,
        ST_REQ2,
        ST_WAIT2,
        ST_OUT
    } state_t;

    // Output bit (5*i+3) mod 16 takes input bit i; stride 5 is odd, so the map is a bijection.
    function automatic logic [DW-1:0] ilv16(input logic [DW-1:0] d);
        logic [DW-1:0]         o;
        logic [$clog2(DW)-1:0] src;
        logic [$clog2(DW)-1:0] dst;
        o = '0;
        for (int i = 0; i < DW; i++) begin
            src    = $clog2(DW)'(i);
            dst    = $clog2(DW)'((ILV_STRIDE * i + ILV_OFFSET) % DW);
            o[dst] = d[src];
        end
        return o;
    endfunction

endpackage

// File: rtl/turbo_enc_ctrl_if.sv
// Upstream block, RSC core and downstream codeword signals of the turbo
// encoder sequencer; slave is the controller side, master the surroundings.
interface turbo_enc_ctrl_if;
    import turbo_pkg::*;

    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;

    logic          rsc_start_o;
    logic          rsc_abort_o;
    logic [DW-1:0] rsc_data_o;
    logic          rsc_done_i;
    logic [CW-1:0] rsc_sys_i;
    logic [CW-1:0] rsc_enc_i;

    logic          out_valid_o;
    logic          out_ready_i;
    logic [CW-1:0] out_sys_o;
    logic [CW-1:0] out_par1_o;
    logic [CW-1:0] out_par2_o;

    modport slave (
        input  in_valid_i, in_data_i, rsc_done_i, rsc_sys_i, rsc_enc_i, out_ready_i,
        output in_ready_o, rsc_start_o, rsc_abort_o, rsc_data_o,
               out_valid_o, out_sys_o, out_par1_o, out_par2_o
    );

    modport master (
        output in_valid_i, in_data_i, rsc_done_i, rsc_sys_i, rsc_enc_i, out_ready_i,
        input  in_ready_o, rsc_start_o, rsc_abort_o, rsc_data_o,
               out_valid_o, out_sys_o, out_par1_o, out_par2_o
    );

endinterface

// File: rtl/turbo_ilv16.sv
// Combinational 16-bit turbo interleaver; no registers, no added latency.
module turbo_ilv16
    import turbo_pkg::*;
(
    input  logic [DW-1:0] data,
    output logic [DW-1:0] perm
);

    assign perm = ilv16(data);

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Turbo encoder sequencer: runs one shared RSC core on the natural and then the
// interleaved block, and holds systematic + two parity words for the packer.
module turbo_enc_ctrl
    import turbo_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 12
) (
    input  logic             clk_p_i,
    input  logic             reset_p_i,
    turbo_enc_ctrl_if.slave  bus,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int TMO_W = $clog2(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [DW-1:0]    blk_r;
    logic [DW-1:0]    blk_ilv;
    logic [CW-1:0]    sys_r;
    logic [CW-1:0]    par1_r;
    logic [CW-1:0]    par2_r;
    logic [TMO_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] blk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             waiting;
    logic             tmo_hit;

    turbo_ilv16 u_ilv (
        .data (blk_r),
        .perm (blk_ilv)
    );

    assign waiting = (state == ST_WAIT1) || (state == ST_WAIT2);
    // A done arriving on the last allowed cycle wins over the timeout.
    assign tmo_hit = waiting && !bus.rsc_done_i && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        bus.in_ready_o  = 1'b0;
        bus.rsc_start_o = 1'b0;
        bus.rsc_data_o  = '0;
        bus.out_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) state_nxt = ST_REQ1;
            end
            ST_REQ1: begin
                bus.rsc_start_o = 1'b1;
                bus.rsc_data_o  = blk_r;
                state_nxt       = ST_WAIT1;
            end
            ST_WAIT1: begin
                bus.rsc_data_o = blk_r;
                if (bus.rsc_done_i) state_nxt = ST_REQ2;
                else if (tmo_hit)   state_nxt = ST_IDLE;
            end
            ST_REQ2: begin
                bus.rsc_start_o = 1'b1;
                bus.rsc_data_o  = blk_ilv;
                state_nxt       = ST_WAIT2;
            end
            ST_WAIT2: begin
                bus.rsc_data_o = blk_ilv;
                if (bus.rsc_done_i) state_nxt = ST_OUT;
                else if (tmo_hit)   state_nxt = ST_IDLE;
            end
            ST_OUT: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            state   <= ST_IDLE;
            blk_r   <= '0;
            sys_r   <= '0;
            par1_r  <= '0;
            par2_r  <= '0;
            tmo_cnt <= '0;
            blk_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.in_valid_i) blk_r <= bus.in_data_i;
            if (state == ST_REQ1 || state == ST_REQ2) tmo_cnt <= '0;
            else if (waiting)                         tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_WAIT1 && bus.rsc_done_i) begin
                sys_r  <= bus.rsc_sys_i;
                par1_r <= bus.rsc_enc_i;
            end
            if (state == ST_WAIT2 && bus.rsc_done_i) par2_r <= bus.rsc_enc_i;
            if (state == ST_OUT && bus.out_ready_i)  blk_cnt <= blk_cnt + 1'b1;
            if (tmo_hit && err_cnt != '1)             err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.rsc_abort_o = tmo_hit;
    assign bus.out_sys_o   = sys_r;
    assign bus.out_par1_o  = par1_r;
    assign bus.out_par2_o  = par2_r;
    assign err_o           = tmo_hit;
    assign blk_cnt_o       = blk_cnt;
    assign err_cnt_o       = err_cnt;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Bench for turbo_enc_ctrl: behavioural (7,5) RSC core model, table-driven blocks,
// corner-case sequences (timeout, done at limit, stray done, reset) and random blocks.
module tb_turbo_enc_ctrl;
    import turbo_pkg::*;

    typedef struct packed {
        logic [CW-1:0] sys;
        logic [CW-1:0] par;
    } cw_t;

    typedef struct {
        logic [DW-1:0] data;
        int            d1;
        int            d2;
        int            hold;
        logic [DW-1:0] exp_p2;
        int            exp_lat;
    } vec_t;

    logic          clk;
    logic          reset_p;
    logic          err_o;
    logic [11:0]   blk_cnt;
    logic [11:0]   err_cnt;
    logic          core_done;
    logic          stray_done;
    logic [CW-1:0] core_sys;
    logic [CW-1:0] core_enc;
    int            core_d1;
    int            core_d2;
    int            core_hold_err = 0;
    int            err_seen = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] core_log [$];
    logic [11:0]   exp_blk;

    turbo_enc_ctrl_if bus ();

    turbo_enc_ctrl #(.TIMEOUT(64), .CNT_W(12)) dut (
        .clk_p_i   (clk),
        .reset_p_i (reset_p),
        .bus       (bus),
        .err_o     (err_o),
        .blk_cnt_o (blk_cnt),
        .err_cnt_o (err_cnt)
    );

    assign bus.rsc_done_i = core_done | stray_done;
    assign bus.rsc_sys_i  = core_sys;
    assign bus.rsc_enc_i  = core_enc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Rate-1/2 RSC, feedback 1+D+D^2, feedforward 1+D^2, two tail bits flushing the state.
    function automatic cw_t rsc_model(input logic [DW-1:0] d);
        cw_t           w;
        logic [DW-1:0] dd;
        logic          s1, s2, u, a;
        w  = '0;
        dd = d;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int k = 0; k < CW; k++) begin
            if (k < DW) begin
                u  = dd[DW-1];
                dd = dd << 1;
            end else begin
                u = s1 ^ s2;
            end
            a     = u ^ s1 ^ s2;
            w.sys = {w.sys[CW-2:0], u};
            w.par = {w.par[CW-2:0], a ^ s2};
            s2    = s1;
            s1    = a;
        end
        return w;
    endfunction

    // Inverse view of the map: output bit j comes from input bit 13*(j-3) mod 16.
    function automatic logic [DW-1:0] ref_ilv(input logic [DW-1:0] d);
        logic [DW-1:0] o;
        o = '0;
        for (int j = 0; j < DW; j++) o[4'(j)] = d[4'((13 * (j + 13)) % 16)];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: sees a start, answers with done after the configured delay (0 = never).
    initial begin
        int            dly;
        logic [DW-1:0] word;
        bit            pass2;
        core_done = 1'b0;
        core_sys  = '0;
        core_enc  = '0;
        pass2     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (bus.in_ready_o === 1'b1) pass2 = 1'b0;
            if (bus.rsc_start_o === 1'b1) begin
                word = bus.rsc_data_o;
                core_log.push_back(word);
                dly   = pass2 ? core_d2 : core_d1;
                pass2 = ~pass2;
                if (dly > 0) begin
                    repeat (dly) @(posedge clk);
                    #1;
                    {core_sys, core_enc} = rsc_model(word);
                    core_done = 1'b1;
                    if (bus.rsc_data_o !== word) core_hold_err++;
                end
            end
        end
    end

    always @(negedge clk) if (err_o === 1'b1) err_seen <= err_seen + 1;

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_start"}, 64'(bus.rsc_start_o), 64'd0);
        check({tag, "_abort"}, 64'(bus.rsc_abort_o), 64'd0);
        check({tag, "_rsc_data"}, 64'(bus.rsc_data_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
        check({tag, "_words"}, 64'({bus.out_sys_o, bus.out_par1_o, bus.out_par2_o}), 64'd0);
    endtask

    // Called and returns just after a falling edge; the current cycle is the first accept candidate.
    task automatic do_block(input logic [DW-1:0] data, input int d1, input int d2, input int hold,
                            input logic [DW-1:0] exp_p2, input int exp_lat,
                            input bit next_valid, input logic [DW-1:0] next_data);
        cw_t              w1, w2;
        int               n, lat, log0;
        logic [3*CW-1:0]  snap;
        core_d1 = d1;
        core_d2 = d2;
        w1      = rsc_model(data);
        w2      = rsc_model(exp_p2);
        log0    = core_log.size();
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = data;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 500), 64'd1);
        @(negedge clk);
        lat = 1;
        bus.in_valid_i = next_valid;
        bus.in_data_i  = next_data;
        check("accepted_ready_low", 64'(bus.in_ready_o), 64'd0);
        while (bus.out_valid_o !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_sys", 64'(bus.out_sys_o), 64'(w1.sys));
        check("out_par1", 64'(bus.out_par1_o), 64'(w1.par));
        check("out_par2", 64'(bus.out_par2_o), 64'(w2.par));
        check("out_ready_low", 64'(bus.in_ready_o), 64'd0);
        check("out_rsc_data", 64'(bus.rsc_data_o), 64'd0);
        check("starts", 64'(core_log.size() - log0), 64'd2);
        if (core_log.size() >= log0 + 2) begin
            check("pass1_in", 64'(core_log[log0]), 64'(data));
            check("pass2_in", 64'(core_log[log0+1]), 64'(exp_p2));
        end
        snap = {bus.out_sys_o, bus.out_par1_o, bus.out_par2_o};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready_o), 64'd0);
            check("hold_words", 64'({bus.out_sys_o, bus.out_par1_o, bus.out_par2_o}), 64'(snap));
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        exp_blk = exp_blk + 12'd1;
        check("post_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("post_valid", 64'(bus.out_valid_o), 64'd0);
        check("blk_cnt", 64'(blk_cnt), 64'(exp_blk));
    endtask

    initial begin
        vec_t          vecs [5];
        int            e0, cyc, ra, rb;
        bit            saw_valid;
        logic [DW-1:0] rd;

        vecs[0] = '{16'h0001, 3, 3, 0, 16'h0008, 9};
        vecs[1] = '{16'hA5C3, 1, 1, 1, 16'h497A, 5};
        vecs[2] = '{16'hFFFF, 2, 5, 0, 16'hFFFF, 10};
        vecs[3] = '{16'h8000, 1, 4, 2, 16'h4000, 8};
        vecs[4] = '{16'h0300, 6, 2, 0, 16'h0801, 11};

        reset_p         = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        stray_done      = 1'b0;
        core_d1         = 1;
        core_d2         = 1;
        exp_blk         = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset_p = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            do_block(vecs[i].data, vecs[i].d1, vecs[i].d2, vecs[i].hold,
                     vecs[i].exp_p2, vecs[i].exp_lat, 1'b0, '0);

        // Back-to-back: valid held high, second block accepted right after the handshake.
        do_block(16'hA5C3, 2, 2, 0, 16'h497A, 7, 1'b1, 16'hFFFF);
        do_block(16'hFFFF, 2, 2, 0, 16'hFFFF, 7, 1'b0, '0);

        // Long backpressure.
        do_block(16'h3C96, 1, 2, 10, ref_ilv(16'h3C96), 6, 1'b0, '0);

        // Pass 2 never completes: timeout 64 cycles after REQ2 (REQ2 is cycle d1+2).
        e0        = err_seen;
        core_d1   = 2;
        core_d2   = 0;
        saw_valid = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 16'h1234;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.in_valid_i = 1'b0;
            if (bus.out_valid_o === 1'b1) saw_valid = 1'b1;
        end while (err_o !== 1'b1 && cyc < 300);
        check("tmo_cycle", 64'(cyc), 64'd68);
        check("tmo_abort", 64'(bus.rsc_abort_o), 64'd1);
        check("tmo_no_valid", 64'(saw_valid), 64'd0);
        @(negedge clk);
        check("tmo_err_pulse", 64'(err_o), 64'd0);
        check("tmo_abort_pulse", 64'(bus.rsc_abort_o), 64'd0);
        check("tmo_idle", 64'(bus.in_ready_o), 64'd1);
        check("tmo_err_cnt", 64'(err_cnt), 64'd1);
        check("tmo_err_seen", 64'(err_seen - e0), 64'd1);
        check("tmo_blk_cnt", 64'(blk_cnt), 64'(exp_blk));
        do_block(16'h0F0F, 1, 1, 0, ref_ilv(16'h0F0F), 5, 1'b0, '0);

        // Done exactly when the counter reaches its limit, on both passes.
        e0 = err_seen;
        do_block(16'hC001, 64, 64, 0, ref_ilv(16'hC001), 131, 1'b0, '0);
        check("limit_no_err", 64'(err_seen - e0), 64'd0);
        check("limit_err_cnt", 64'(err_cnt), 64'd1);

        // Stray done in IDLE and REQ1, then reset during WAIT1.
        e0         = err_seen;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_idle_ready", 64'(bus.in_ready_o), 64'd1);
        check("stray_idle_start", 64'(bus.rsc_start_o), 64'd0);
        core_d1 = 0;
        core_d2 = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 16'h5A5A;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        check("req1_start", 64'(bus.rsc_start_o), 64'd1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_req1_start", 64'(bus.rsc_start_o), 64'd0);
        check("stray_req1_data", 64'(bus.rsc_data_o), 64'h5A5A);
        repeat (3) @(negedge clk);
        reset_p = 1'b1;
        @(negedge clk);
        reset_p = 1'b0;
        exp_blk = '0;
        check_idle("midrst");
        @(negedge clk);
        check("midrst_no_err", 64'(err_seen - e0), 64'd0);

        for (int i = 0; i < 24; i++) begin
            rd = DW'($urandom);
            ra = int'($urandom_range(1, 8));
            rb = int'($urandom_range(1, 8));
            do_block(rd, ra, rb, int'($urandom_range(0, 3)), ref_ilv(rd), ra + rb + 3, 1'b0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        check("core_hold", 64'(core_hold_err), 64'd0);
        check("err_total", 64'(err_seen), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
